// File: rtl/dff_init_sequencer_pkg.sv
// Shared types and constants for the flip-flop bank init sequencer.
package dff_init_sequencer_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ASSERT = 2'd1;
  localparam state_t ST_GAP    = 2'd2;
  localparam state_t ST_DONE   = 2'd3;

  // Inactive level of one flip-flop's control pair: clear is active-low, preset active-high.
  typedef struct packed {
    logic reset_n;
    logic preset;
  } line_pair_t;

  localparam line_pair_t INIT_IDLE_LINES = '{reset_n: 1'b1, preset: 1'b0};

endpackage

// File: rtl/dff_init_sequencer.sv
// Walks a bank of async preset/clear flip-flops one at a time, driving each
// to its latched target value with a programmable hold and a quiet gap.
module dff_init_sequencer
  import dff_init_sequencer_pkg::*;
#(
  parameter int NUM_REGS    = 8,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2
) (
  input  logic                                            iClock,
  input  logic                                            iReset,
  input  logic                                            iStart,
  input  logic [NUM_REGS-1:0]                             iPattern,
  input  logic                                            iAbort,
  output logic [NUM_REGS-1:0]                             oRegReset,
  output logic [NUM_REGS-1:0]                             oRegPreset,
  output logic [((NUM_REGS > 1) ? $clog2(NUM_REGS) : 1)-1:0] oIndex,
  output logic                                            oBusy,
  output logic                                            oDone
);

  localparam int IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]    HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]    GAP_LAST     = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0]    LAST_IDX     = IDX_W'(NUM_REGS - 1);
  localparam logic [NUM_REGS-1:0] IDLE_RESET   = {NUM_REGS{INIT_IDLE_LINES.reset_n}};
  localparam logic [NUM_REGS-1:0] IDLE_PRESET  = {NUM_REGS{INIT_IDLE_LINES.preset}};

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_REGS-1:0] pattern_q, pattern_d;

  logic [NUM_REGS-1:0] reg_reset_q, reg_reset_d;
  logic [NUM_REGS-1:0] reg_preset_q, reg_preset_d;
  logic [IDX_W-1:0]    index_q, index_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    pattern_d = pattern_q;
    case (state_q)
      ST_IDLE: begin
        if (iStart) begin
          pattern_d = iPattern;
          idx_d     = '0;
          cnt_d     = '0;
          state_d   = ST_ASSERT;
        end
      end
      ST_ASSERT: begin
        // Abort wins over counter expiry in the same cycle.
        if (iAbort) begin
          state_d = ST_IDLE;
        end else if (cnt_q == HOLD_LAST) begin
          cnt_d = '0;
          if (GAP_CYCLES > 0)          state_d = ST_GAP;
          else if (idx_q == LAST_IDX)  state_d = ST_DONE;
          else                         idx_d   = idx_q + IDX_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (iAbort) begin
          state_d = ST_IDLE;
        end else if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ST_ASSERT;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the current state and registered, so the bank
  // only ever sees flop outputs.
  always_comb begin
    reg_reset_d  = IDLE_RESET;
    reg_preset_d = IDLE_PRESET;
    if (state_q == ST_ASSERT) begin
      if (pattern_q[idx_q]) reg_preset_d[idx_q] = 1'b1;
      else                  reg_reset_d[idx_q]  = 1'b0;
    end
    busy_d  = (state_q == ST_ASSERT) || (state_q == ST_GAP);
    done_d  = (state_q == ST_DONE);
    index_d = idx_q;
  end

  always_ff @(posedge iClock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!iReset) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      pattern_q    <= '0;
      reg_reset_q  <= IDLE_RESET;
      reg_preset_q <= IDLE_PRESET;
      index_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      pattern_q    <= pattern_d;
      reg_reset_q  <= reg_reset_d;
      reg_preset_q <= reg_preset_d;
      index_q      <= index_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign oRegReset  = reg_reset_q;
  assign oRegPreset = reg_preset_q;
  assign oIndex     = index_q;
  assign oBusy      = busy_q;
  assign oDone      = done_q;

endmodule

// File: tb/tb_dff_init_sequencer.sv
// Directed bench for dff_init_sequencer: one instance with a gap (4/3/2) and
// one without (4/1/0); cycle c is the interval after the c-th edge past start.
module tb_dff_init_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start_a, abort_a, start_b, abort_b;
  logic [3:0] pattern_a, pattern_b;
  logic [3:0] rr_a, pr_a, rr_b, pr_b;
  logic [1:0] idx_a, idx_b;
  logic       busy_a, done_a, busy_b, done_b;
  logic       mon_en;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [9:0] IDLE_V = 10'b1111_0000_0_0;

  dff_init_sequencer #(.NUM_REGS(4), .HOLD_CYCLES(3), .GAP_CYCLES(2)) u_dut_a (
    .iClock(clk), .iReset(rst_n), .iStart(start_a), .iPattern(pattern_a), .iAbort(abort_a),
    .oRegReset(rr_a), .oRegPreset(pr_a), .oIndex(idx_a), .oBusy(busy_a), .oDone(done_a)
  );

  dff_init_sequencer #(.NUM_REGS(4), .HOLD_CYCLES(1), .GAP_CYCLES(0)) u_dut_b (
    .iClock(clk), .iReset(rst_n), .iStart(start_b), .iPattern(pattern_b), .iAbort(abort_b),
    .oRegReset(rr_b), .oRegPreset(pr_b), .oIndex(idx_b), .oBusy(busy_b), .oDone(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Expected {reset_n[3:0], preset[3:0], busy, done} r cycles after the start-accept edge.
  function automatic logic [9:0] exp_lines(int r, logic [3:0] pat, int hold, int gap);
    logic [3:0] rn;
    logic [3:0] pr;
    logic       busy;
    logic       done;
    int         per;
    int         k;
    int         ph;
    rn   = 4'hf;
    pr   = 4'h0;
    per  = hold + gap;
    busy = (r >= 1) && (r <= 4 * per);
    done = (r == 4 * per + 1);
    if (busy) begin
      k  = (r - 1) / per;
      ph = (r - 1) % per;
      if (ph < hold) begin
        if (pat[k]) pr[k] = 1'b1;
        else        rn[k] = 1'b0;
      end
    end
    return {rn, pr, busy, done};
  endfunction

  function automatic int exp_index(int r, int hold, int gap);
    if (r >= 1 && r <= 4 * (hold + gap)) return (r - 1) / (hold + gap);
    return -1;
  endfunction

  function automatic logic excl_bad(logic [3:0] rn, logic [3:0] pr);
    logic [3:0] act;
    act = ~rn | pr;
    return ((~rn & pr) != 4'b0) || ($countones(act) > 1);
  endfunction

  task automatic chk_cycle(input string tag, input int c, input logic [9:0] obs,
                           input logic [1:0] obs_idx, input logic [9:0] exp, input int exp_idx);
    check($sformatf("%s_c%0d_lines", tag, c), {22'b0, obs}, {22'b0, exp});
    if (exp_idx >= 0) check($sformatf("%s_c%0d_idx", tag, c), {30'b0, obs_idx}, exp_idx);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("excl_a", {31'b0, excl_bad(rr_a, pr_a)}, 32'd0);
      check("excl_b", {31'b0, excl_bad(rr_b, pr_b)}, 32'd0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    mon_en    = 1'b0;
    rst_n     = 1'b0;
    start_a   = 1'b1;
    start_b   = 1'b1;
    abort_a   = 1'b0;
    abort_b   = 1'b0;
    pattern_a = 4'b1010;
    pattern_b = 4'b1111;

    // Reset held three cycles with start asserted: everything stays at reset values.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("rst_a_c%0d", c), {20'b0, rr_a, pr_a, idx_a, busy_a, done_a}, 32'h0f00 >> 0 & 32'hfff | 32'hf00);
      check($sformatf("rst_b_c%0d", c), {20'b0, rr_b, pr_b, idx_b, busy_b, done_b}, 32'hf00);
    end
    start_a = 1'b0;
    start_b = 1'b0;
    rst_n   = 1'b1;
    mon_en  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_idle_a", {22'b0, rr_a, pr_a, busy_a, done_a}, {22'b0, IDLE_V});
    end

    // Normal run, pattern 1010; pattern and start are disturbed mid-sequence.
    pattern_a = 4'b1010;
    start_a   = 1'b1;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (c == 0) start_a = 1'b0;
      chk_cycle("norm", c, {rr_a, pr_a, busy_a, done_a}, idx_a,
                exp_lines(c, 4'b1010, 3, 2), exp_index(c, 3, 2));
      if (c == 4)  pattern_a = 4'b0101;
      if (c == 9)  start_a   = 1'b1;
      if (c == 11) start_a   = 1'b0;
    end

    // No-gap instance: preset walks one-hot; start held high restarts on the first IDLE cycle.
    pattern_b = 4'b1111;
    start_b   = 1'b1;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (c <= 5) chk_cycle("nogap", c, {rr_b, pr_b, busy_b, done_b}, idx_b,
                            exp_lines(c, 4'b1111, 1, 0), exp_index(c, 1, 0));
      else        chk_cycle("b2b", c, {rr_b, pr_b, busy_b, done_b}, idx_b,
                            exp_lines(c - 6, 4'b0110, 1, 0), exp_index(c - 6, 1, 0));
      if (c == 2) pattern_b = 4'b0110;
      if (c == 6) start_b   = 1'b0;
    end

    // Abort on the last gap cycle of index 0, then restart at cycle 7 with a new pattern.
    repeat (2) @(negedge clk);
    pattern_a = 4'b1010;
    start_a   = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (c <= 5)      chk_cycle("abort", c, {rr_a, pr_a, busy_a, done_a}, idx_a,
                                 exp_lines(c, 4'b1010, 3, 2), exp_index(c, 3, 2));
      else if (c < 7)  chk_cycle("abort", c, {rr_a, pr_a, busy_a, done_a}, idx_a, IDLE_V, -1);
      else             chk_cycle("restart", c, {rr_a, pr_a, busy_a, done_a}, idx_a,
                                 exp_lines(c - 7, 4'b1011, 3, 2), exp_index(c - 7, 3, 2));
      if (c == 0) start_a = 1'b0;
      if (c == 4) abort_a = 1'b1;
      if (c == 5) abort_a = 1'b0;
      if (c == 6) begin
        start_a   = 1'b1;
        pattern_a = 4'b1011;
      end
      if (c == 7) start_a = 1'b0;
    end

    // Reset mid-sequence: outputs return to reset values at once and no done follows.
    repeat (2) @(negedge clk);
    pattern_a = 4'b0001;
    start_a   = 1'b1;
    for (int c = 0; c < 26; c++) begin
      @(negedge clk);
      if (c == 1)      chk_cycle("midrst", c, {rr_a, pr_a, busy_a, done_a}, idx_a,
                                 exp_lines(1, 4'b0001, 3, 2), 0);
      else if (c >= 2) chk_cycle("midrst", c, {rr_a, pr_a, busy_a, done_a}, idx_a, IDLE_V,
                                 (c == 2) ? 0 : -1);
      if (c == 0) start_a = 1'b0;
      if (c == 1) rst_n   = 1'b0;
      if (c == 2) rst_n   = 1'b1;
    end

    // Random starts, patterns and aborts; the exclusivity monitor watches every cycle.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      start_a   = ($urandom_range(3) == 0);
      abort_a   = ($urandom_range(9) == 0);
      pattern_a = 4'($urandom);
      start_b   = ($urandom_range(3) == 0);
      abort_b   = ($urandom_range(9) == 0);
      pattern_b = 4'($urandom);
    end
    start_a = 1'b0;
    abort_a = 1'b0;
    start_b = 1'b0;
    abort_b = 1'b0;
    repeat (30) @(negedge clk);
    check("drain_idle_a", {22'b0, rr_a, pr_a, busy_a, done_a}, {22'b0, IDLE_V});
    check("drain_idle_b", {22'b0, rr_b, pr_b, busy_b, done_b}, {22'b0, IDLE_V});

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
